// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async_fifo write-side arbiter: default sizes,
// arbiter state encoding and the rotating-priority search helper.
package async_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int ARB_NUM_REQ     = 4;
    localparam int ARB_BURST_LEN   = 4;

    // Widest requester vector the search helper handles.
    localparam int RR_MAX_REQ      = 8;

    typedef enum logic {
        ARB_S  = 1'b0,
        HOLD_S = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0], searched from last+1 upward with wrap.
    // When nothing is valid, idx still points at last+1 so callers can show
    // the next candidate position.
    function automatic rr_pick_t rr_next(input logic [RR_MAX_REQ-1:0] valid,
                                         input logic [2:0]            last,
                                         input int                    n);
        rr_pick_t pick;
        int       j;
        j          = (int'(last) + 1) % n;
        pick.found = 1'b0;
        pick.idx   = 3'(j);
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            j = (int'(last) + k) % n;
            if ((k <= n) && !pick.found && valid[j]) begin
                pick.found = 1'b1;
                pick.idx   = 3'(j);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/async_fifo_rr_picker.sv
// Purely combinational rotating-priority picker. Given a request vector and
// the index served last, returns the next requester at or after last+1.
// Kept free of any write-side detail so a read-side scheduler can reuse it.
module async_fifo_rr_picker
    import async_fifo_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int IDW = $clog2(NUM_REQ);

    rr_pick_t pick;

    // Zero-extend into the helper's fixed width and narrow the result back.
    always_comb begin
        pick  = rr_next(RR_MAX_REQ'(valid), 3'(last), NUM_REQ);
        idx   = IDW'(pick.idx);
        found = pick.found;
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the async_fifo write port among
// NUM_REQ producers in the wclk domain. Respects wfull so no write ever goes
// to a full FIFO; transfers are zero-latency (winc/wdata follow the winner
// combinationally). Optional statistics counters are built when
// ASYNC_FIFO_ARB_STATS_EN is defined.
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BURST_LEN  = ARB_BURST_LEN
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          wfull,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
`ifdef ASYNC_FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                   stall_cnt,
    output logic [31:0]                   beat_cnt_total
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(BURST_LEN + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_id_q, last_id_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0] arb_idx;
    logic           arb_found;
    logic [IDW-1:0] cand;
    logic           cand_valid;
    logic           owner_valid;
    logic           fire;

    async_fifo_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (req_valid),
        .last  (last_id_q),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Candidate selection, write strobe and per-producer accept.
    // Everything is forced inactive while wrst is high so an in-flight beat
    // is dropped the moment reset asserts.
    always_comb begin
        cand        = (state_q == HOLD_S) ? owner_q : arb_idx;
        cand_valid  = 1'b0;
        owner_valid = 1'b0;
        wdata       = req_data[DATA_WIDTH-1:0];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand == IDW'(i)) begin
                cand_valid = req_valid[i];
                wdata      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (owner_q == IDW'(i)) begin
                owner_valid = req_valid[i];
            end
        end

        fire = cand_valid && !wfull && !wrst &&
               ((state_q == HOLD_S) || arb_found);

        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = fire && (cand == IDW'(i));
        end

        winc     = fire;
        grant_id = wrst ? '0 : cand;
        busy     = (state_q == HOLD_S) && !wrst;
    end

    // Next-state: open a burst on an ARB fire, count beats in HOLD, and
    // release on burst completion or when the owner stops requesting.
    // Stalls on wfull leave every register untouched.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_id_d  = last_id_q;
        beat_cnt_d = beat_cnt_q;

        case (state_q)
            ARB_S: begin
                if (fire) begin
                    if (BURST_LEN == 1) begin
                        last_id_d = cand;
                    end else begin
                        owner_d    = cand;
                        beat_cnt_d = BCW'(1);
                        state_d    = HOLD_S;
                    end
                end
            end
            HOLD_S: begin
                if (!owner_valid) begin
                    last_id_d  = owner_q;
                    beat_cnt_d = '0;
                    state_d    = ARB_S;
                end else if (fire) begin
                    if ((int'(beat_cnt_q) + 1) == BURST_LEN) begin
                        last_id_d  = owner_q;
                        beat_cnt_d = '0;
                        state_d    = ARB_S;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d = ARB_S;
            end
        endcase
    end

    // Arbiter registers; last_id resets to the top index so producer 0 is
    // searched first after reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q    <= ARB_S;
            owner_q    <= '0;
            last_id_q  <= IDW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_id_q  <= last_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef ASYNC_FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] beat_cnt_total_q, beat_cnt_total_d;

    // Saturating count of cycles where someone wants to write but the FIFO
    // is full, and a wrapping count of accepted beats.
    always_comb begin
        stall_cnt_d      = stall_cnt_q;
        beat_cnt_total_d = beat_cnt_total_q;
        if ((|req_valid) && wfull && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (fire) begin
            beat_cnt_total_d = beat_cnt_total_q + 32'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            stall_cnt_q      <= '0;
            beat_cnt_total_q <= '0;
        end else begin
            stall_cnt_q      <= stall_cnt_d;
            beat_cnt_total_q <= beat_cnt_total_d;
        end
    end

    assign stall_cnt      = stall_cnt_q;
    assign beat_cnt_total = beat_cnt_total_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed and randomized checks of async_fifo_wr_arbiter against a
// behavioural model of the round-robin, burst-bounded sharing rules.
module tb_async_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic          wclk = 1'b0;
    logic          wrst;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          wfull;
    logic          winc;
    logic [DW-1:0] wdata;
    logic [1:0]    grant_id;
    logic          busy;
`ifdef ASYNC_FIFO_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [31:0]   beat_cnt_total;
`endif

    logic [DW-1:0] d [N];

    async_fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef ASYNC_FIFO_ARB_STATS_EN
        ,
        .stall_cnt      (stall_cnt),
        .beat_cnt_total (beat_cnt_total)
`endif
    );

    always #5 wclk = ~wclk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
    end

    // Model: m_owner < 0 means nobody holds the port.
    int m_owner, m_last, m_beats;
    int m_stall, m_fires;
    int e_cand;
    bit e_fire, e_busy;
    int n_cmp, n_err;
    int fire_ids[$];
    logic [DW-1:0] fire_data[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
        m_stall = 0;
        m_fires = 0;
    endfunction

    function automatic void model_eval();
        int j;
        e_fire = 1'b0;
        e_busy = 1'b0;
        e_cand = 0;
        if (wrst) return;
        if (m_owner >= 0) begin
            e_busy = 1'b1;
            e_cand = m_owner;
            e_fire = req_valid[m_owner] && !wfull;
        end else begin
            e_cand = (m_last + 1) % N;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (req_valid[j]) begin
                    e_cand = j;
                    e_fire = !wfull;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_step();
        if ((|req_valid) && wfull && m_stall < 65535) m_stall++;
        if (e_fire) m_fires++;
        if (m_owner >= 0) begin
            if (!req_valid[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else if (e_fire) begin
                m_beats++;
                if (m_beats == BL) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end else if (e_fire) begin
            if (BL == 1) m_last = e_cand;
            else begin
                m_owner = e_cand;
                m_beats = 1;
            end
        end
    endfunction

    // One clock: check outputs at the falling edge, advance model at rising.
    task automatic cycle();
        logic [N-1:0] er;
        @(negedge wclk);
        model_eval();
        er = e_fire ? N'(1 << e_cand) : '0;
        chk("winc", 32'(winc), 32'(e_fire));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("grant_id", 32'(grant_id), 32'(e_cand));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_fire) chk("wdata", 32'(wdata), 32'(d[e_cand]));
`ifdef ASYNC_FIFO_ARB_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("beat_cnt_total", beat_cnt_total, 32'(m_fires));
`endif
        @(posedge wclk);
        if (wrst) model_reset();
        else begin
            if (e_fire) begin
                fire_ids.push_back(e_cand);
                fire_data.push_back(d[e_cand]);
            end
            model_step();
        end
        #1;
    endtask

    task automatic next_data();
        if (e_fire) d[e_cand] = d[e_cand] + 8'd1;
    endtask

    task automatic reset_pulse();
        wrst      = 1'b1;
        req_valid = '0;
        wfull     = 1'b0;
        model_reset();
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        fire_ids.delete();
        fire_data.delete();
    endtask

    int got;

    initial begin
        n_cmp = 0;
        n_err = 0;
        wrst  = 1'b1;
        wfull = 1'b0;
        req_valid = '0;
        for (int i = 0; i < N; i++) d[i] = 8'(16 * i);
        model_reset();

        // Held in reset with all producers requesting: everything quiet.
        #2;
        req_valid = 4'hF;
        cycle();
        cycle();
        wrst = 1'b0;
        fire_ids.delete();

        // All four requesting: 0,1,2,3 each for a full burst, no bubbles.
        repeat (16) begin
            cycle();
            next_data();
        end
        chk("rr_count", 32'(fire_ids.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            got = (k < fire_ids.size()) ? fire_ids[k] : 99;
            chk("rr_order", 32'(got), 32'(k / BL));
        end

        // Single producer 2 streams A0..A9 back to back across re-grants.
        reset_pulse();
        req_valid = 4'b0100;
        d[2] = 8'hA0;
        repeat (10) begin
            cycle();
            next_data();
        end
        chk("solo_count", 32'(fire_ids.size()), 32'd10);
        for (int k = 0; k < 10; k++) begin
            got = (k < fire_data.size()) ? int'(fire_data[k]) : 999;
            chk("solo_data", 32'(got), 32'(8'hA0 + k));
        end
        req_valid = '0;
        cycle();

        // wfull stalls producer 0 after beat 2; burst finishes before 1.
        reset_pulse();
        req_valid = 4'b0011;
        repeat (2) begin cycle(); next_data(); end
        wfull = 1'b1;
        repeat (5) cycle();
        wfull = 1'b0;
        repeat (4) begin cycle(); next_data(); end
        chk("stall_count", 32'(fire_ids.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            got = (k < fire_ids.size()) ? fire_ids[k] : 99;
            chk("stall_order", 32'(got), (k < 4) ? 32'd0 : 32'd1);
        end

        // Producer 3 leaves after one beat; release cycle has no write.
        reset_pulse();
        req_valid = 4'b1000;
        cycle();
        req_valid = 4'b0010;
        cycle();
        chk("drop_no_write", 32'(fire_ids.size()), 32'd1);
        cycle();
        got = (fire_ids.size() > 1) ? fire_ids[1] : 99;
        chk("drop_next", 32'(got), 32'd1);
        req_valid = '0;
        cycle();

        // Asynchronous reset during beat 2 of producer 1.
        reset_pulse();
        req_valid = 4'b0010;
        cycle();
        @(negedge wclk);
        #1;
        chk("pre_rst_winc", 32'(winc), 32'd1);
        wrst = 1'b1;
        #1;
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        model_reset();
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        req_valid = 4'hF;
        fire_ids.delete();
        cycle();
        got = (fire_ids.size() > 0) ? fire_ids[0] : 99;
        chk("post_rst_first", 32'(got), 32'd0);

        // Randomized traffic with back-pressure and occasional withdrawals.
        reset_pulse();
        repeat (3000) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && e_fire && e_cand == i) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    d[i] = 8'($urandom);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    d[i] = 8'($urandom);
                end
            end
            wfull = ($urandom_range(0, 3) == 0);
        end

`ifdef ASYNC_FIFO_ARB_STATS_EN
        // 12 fires then 7 stalled cycles, then long stall for saturation.
        reset_pulse();
        req_valid = 4'hF;
        repeat (12) begin cycle(); next_data(); end
        wfull = 1'b1;
        repeat (7) cycle();
        #1;
        chk("stats_stall7", 32'(stall_cnt), 32'd7);
        chk("stats_fire12", beat_cnt_total, 32'd12);
        repeat (70000) @(posedge wclk);
        #1;
        chk("stats_sat", 32'(stall_cnt), 32'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
